// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes the pin, majority-votes mid-bit samples and
// presents each byte through a valid/ready output register with error pulses.
module uart_byte_rx #(
    parameter int unsigned CLK_FRE   = 200,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned CYCLES_PER_BIT = CLK_FRE * 1_000_000 / BAUD_RATE;
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_CNT_W      = 3;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 8) begin : g_bad_baud
            $error("uart_byte_rx: CYCLES_PER_BIT must be at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic [2:0]           hist;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shift;
    logic                 line;
    logic                 fall;
    logic                 vote;
    logic                 out_free;

    // Synchronizer and history reset high so reset release looks like an idle line
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            hist <= 3'b111;
        end else begin
            sync <= {sync[0], uart_rx};
            hist <= {hist[1:0], sync[1]};
        end
    end

    assign line     = sync[1];
    assign fall     = hist[0] & ~line;
    assign vote     = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    // A byte leaving on this edge frees the register for a byte arriving on it
    assign out_free = ~rx_data_valid | rx_data_ready;

    // Frame FSM with the output register and error pulses
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF_END) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        if (!vote) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt     <= '0;
                        shift   <= {vote, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_W'(7)) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (vote) begin
                            if (out_free) begin
                                rx_data       <= shift;
                                rx_data_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 cycles per bit (1 MHz clock, 62500 baud).
module tb_uart_byte_rx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int         compared = 0;
    int         mismatched = 0;
    int         xfer_cnt = 0;
    int         ferr_cycles = 0;
    int         ovr_cycles = 0;
    logic [7:0] last_xfer = 8'h00;

    uart_byte_rx #(
        .CLK_FRE   (1),
        .BAUD_RATE (62500)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Log handshake transfers and count cycles each error pulse is high
    always @(posedge sys_clk) begin
        if (rx_data_valid && rx_data_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_xfer <= rx_data;
        end
        if (rx_frame_err) ferr_cycles <= ferr_cycles + 1;
        if (rx_overrun)   ovr_cycles  <= ovr_cycles + 1;
    end

    function automatic logic line_bit(input logic [7:0] b, input logic stop, input int c);
        int idx;
        idx = c / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return stop;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_at);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge sys_clk);
            uart_rx = line_bit(b, stop, c);
            if (ready_at >= 0) begin
                if (c == ready_at) rx_data_ready = 1'b1;
                else if (c == ready_at + 1) rx_data_ready = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", rx_data); end
        compared++; if (rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", rx_data_valid); end
        compared++; if (rx_frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
        compared++; if (rx_overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst_n = 1'b1;
        idle(20);
        compared++; if (rx_busy !== 1'b0 || rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL reset_release: got busy=%b valid=%b want 0/0", rx_busy, rx_data_valid); end
    endtask

    task automatic test_basic();
        int x0, f0, o0;
        x0 = xfer_cnt; f0 = ferr_cycles; o0 = ovr_cycles;
        rx_data_ready = 1'b1;
        send_frame(8'hA3, 1'b1, -1);
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy: got %b want 0", rx_busy); end
        idle(4);
        compared++; if (xfer_cnt !== x0 + 1) begin mismatched++; $display("FAIL basic_xfer_count: got %0d want %0d", xfer_cnt, x0 + 1); end
        compared++; if (last_xfer !== 8'hA3) begin mismatched++; $display("FAIL basic_data: got %h want a3", last_xfer); end
        compared++; if (ferr_cycles !== f0 || ovr_cycles !== o0) begin mismatched++; $display("FAIL basic_errors: got ferr=%0d ovr=%0d want %0d/%0d", ferr_cycles, ovr_cycles, f0, o0); end
        compared++; if (rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL basic_valid_clear: got %b want 0", rx_data_valid); end
    endtask

    task automatic test_frame_err();
        int x0, f0;
        x0 = xfer_cnt; f0 = ferr_cycles;
        send_frame(8'hA3, 1'b0, -1);
        idle(20);
        compared++; if (ferr_cycles !== f0 + 1) begin mismatched++; $display("FAIL frame_err_pulse: got %0d cycles want %0d", ferr_cycles - f0, 1); end
        compared++; if (xfer_cnt !== x0 || rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL frame_err_no_valid: got xfers=%0d valid=%b want %0d/0", xfer_cnt, rx_data_valid, x0); end
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL frame_err_idle: got busy=%b want 0", rx_busy); end
    endtask

    task automatic test_break();
        int f0, x0;
        f0 = ferr_cycles; x0 = xfer_cnt;
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (3 * FRAME) @(negedge sys_clk);
        idle(20);
        compared++; if (ferr_cycles !== f0 + 1) begin mismatched++; $display("FAIL break_single_err: got %0d cycles want 1", ferr_cycles - f0); end
        compared++; if (rx_busy !== 1'b0 || xfer_cnt !== x0) begin mismatched++; $display("FAIL break_idle: got busy=%b xfers=%0d want 0/%0d", rx_busy, xfer_cnt, x0); end
    endtask

    task automatic test_glitch();
        int x0, f0;
        x0 = xfer_cnt; f0 = ferr_cycles;
        @(negedge sys_clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        compared++; if (rx_busy !== 1'b1) begin mismatched++; $display("FAIL glitch_busy_high: got %b want 1", rx_busy); end
        idle(20);
        compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy_low: got %b want 0", rx_busy); end
        compared++; if (xfer_cnt !== x0 || rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL glitch_no_valid: got xfers=%0d valid=%b want %0d/0", xfer_cnt, rx_data_valid, x0); end
        compared++; if (ferr_cycles !== f0) begin mismatched++; $display("FAIL glitch_no_err: got %0d want %0d", ferr_cycles, f0); end
    endtask

    task automatic test_overrun();
        int x0, o0, f0;
        x0 = xfer_cnt; o0 = ovr_cycles; f0 = ferr_cycles;
        rx_data_ready = 1'b0;
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        idle(2);
        compared++; if (rx_data_valid !== 1'b1) begin mismatched++; $display("FAIL overrun_valid: got %b want 1", rx_data_valid); end
        compared++; if (rx_data !== 8'h55) begin mismatched++; $display("FAIL overrun_data_kept: got %h want 55", rx_data); end
        compared++; if (ovr_cycles !== o0 + 1) begin mismatched++; $display("FAIL overrun_pulse: got %0d cycles want 1", ovr_cycles - o0); end
        compared++; if (ferr_cycles !== f0) begin mismatched++; $display("FAIL overrun_no_ferr: got %0d want %0d", ferr_cycles, f0); end
        rx_data_ready = 1'b1;
        @(negedge sys_clk);
        compared++; if (rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL overrun_drain_valid: got %b want 0", rx_data_valid); end
        compared++; if (xfer_cnt !== x0 + 1 || last_xfer !== 8'h55) begin mismatched++; $display("FAIL overrun_drain_xfer: got n=%0d data=%h want %0d/55", xfer_cnt, last_xfer, x0 + 1); end
        rx_data_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        int x0, o0;
        x0 = xfer_cnt; o0 = ovr_cycles;
        rx_data_ready = 1'b0;
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'h0F, 1'b1, 154);
        idle(2);
        compared++; if (xfer_cnt !== x0 + 1 || last_xfer !== 8'h55) begin mismatched++; $display("FAIL simul_first_xfer: got n=%0d data=%h want %0d/55", xfer_cnt, last_xfer, x0 + 1); end
        compared++; if (rx_data_valid !== 1'b1) begin mismatched++; $display("FAIL simul_valid: got %b want 1", rx_data_valid); end
        compared++; if (rx_data !== 8'h0F) begin mismatched++; $display("FAIL simul_data: got %h want 0f", rx_data); end
        compared++; if (ovr_cycles !== o0) begin mismatched++; $display("FAIL simul_no_overrun: got %0d want %0d", ovr_cycles, o0); end
        rx_data_ready = 1'b1;
        idle(2);
        compared++; if (last_xfer !== 8'h0F || rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL simul_drain: got data=%h valid=%b want 0f/0", last_xfer, rx_data_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int x0, f0;
        x0 = xfer_cnt; f0 = ferr_cycles;
        rx_data_ready = 1'b1;
        for (int c = 0; c < 88; c++) begin
            @(negedge sys_clk);
            uart_rx = line_bit(8'hA3, 1'b1, c);
        end
        @(negedge sys_clk);
        compared++; if (rx_busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %b want 1", rx_busy); end
        uart_rx = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        compared++; if (rx_busy !== 1'b0 || rx_data_valid !== 1'b0) begin mismatched++; $display("FAIL mid_reset_state: got busy=%b valid=%b want 0/0", rx_busy, rx_data_valid); end
        compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL mid_reset_data: got %h want 00", rx_data); end
        #99 rst_n = 1'b1;
        idle(30);
        compared++; if (xfer_cnt !== x0) begin mismatched++; $display("FAIL mid_aborted_output: got %0d xfers want %0d", xfer_cnt, x0); end
        send_frame(8'h3C, 1'b1, -1);
        idle(4);
        compared++; if (xfer_cnt !== x0 + 1 || last_xfer !== 8'h3C) begin mismatched++; $display("FAIL mid_clean_byte: got n=%0d data=%h want %0d/3c", xfer_cnt, last_xfer, x0 + 1); end
        compared++; if (ferr_cycles !== f0 || rx_busy !== 1'b0) begin mismatched++; $display("FAIL mid_clean_state: got ferr=%0d busy=%b want %0d/0", ferr_cycles, rx_busy, f0); end
        rx_data_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_break();
        test_glitch();
        test_overrun();
        test_simultaneous();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
